// File: rtl/mem_lsu.sv
// mem_lsu -- load/store unit between EX and an SRAM-like data port.
//
// Accepts one memory instruction at a time from EX, issues it as a single
// request on the data_* port, and reports completion to WB as a one-cycle
// out_valid pulse carrying the extended load result.
//
// Ports
//   clk, resetn                    clock, asynchronous active-low reset
//   in_valid, in_op, in_except     EX instruction, one-hot op, pre-flagged exception
//   in_addr, in_wdata, in_rf_waddr effective address, raw store data, load target
//   flush                          kills the access in flight
//   stallreq                       holds EX and upstream stages
//   data_req, data_wr, data_size,
//   data_addr, data_wdata,
//   data_wstrb                     request side of the data port
//   data_addr_ok, data_data_ok,
//   data_rdata                     handshake and response of the data port
//   out_valid, out_rf_we,
//   out_rf_waddr, out_rdata        registered completion toward WB
module mem_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_op,
  input  logic        in_except,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rf_waddr,
  input  logic        flush,
  output logic        stallreq,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        out_valid,
  output logic        out_rf_we,
  output logic [4:0]  out_rf_waddr,
  output logic [31:0] out_rdata
);

  // One-hot op bit positions: {lb,lbu,lh,lhu,lw,sb,sh,sw}
  localparam int OP_LB  = 7;
  localparam int OP_LBU = 6;
  localparam int OP_LH  = 5;
  localparam int OP_LHU = 4;
  localparam int OP_LW  = 3;
  localparam int OP_SB  = 2;
  localparam int OP_SH  = 1;
  localparam int OP_SW  = 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t      r_state;
  logic [7:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_waddr;
  logic        r_out_valid;
  logic        r_out_rf_we;
  logic [4:0]  r_out_rf_waddr;
  logic [31:0] r_out_rdata;

  logic        w_accept;
  logic        w_in_req;
  logic        w_is_load;
  logic        w_is_store;
  logic [31:0] w_load_data;

  function automatic logic [1:0] f_size(input logic [7:0] op);
    if (op[OP_LB] | op[OP_LBU] | op[OP_SB])      f_size = 2'd0;
    else if (op[OP_LH] | op[OP_LHU] | op[OP_SH]) f_size = 2'd1;
    else                                         f_size = 2'd2;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [7:0] op, input logic [1:0] a);
    if (op[OP_SB])      f_wstrb = 4'b0001 << a;
    else if (op[OP_SH]) f_wstrb = a[1] ? 4'b1100 : 4'b0011;
    else if (op[OP_SW]) f_wstrb = 4'b1111;
    else                f_wstrb = 4'b0000;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [7:0] op, input logic [31:0] wd);
    if (op[OP_SB])      f_wdata = {4{wd[7:0]}};
    else if (op[OP_SH]) f_wdata = {2{wd[15:0]}};
    else                f_wdata = wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [7:0] op, input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    if (op[OP_LB])       f_load = {{24{b[7]}}, b};
    else if (op[OP_LBU]) f_load = {24'd0, b};
    else if (op[OP_LH])  f_load = {{16{h[15]}}, h};
    else if (op[OP_LHU]) f_load = {16'd0, h};
    else if (op[OP_LW])  f_load = rd;
    else                 f_load = 32'd0;
  endfunction

  // Gating with resetn keeps stallreq at 0 while reset is held even though
  // the accept term looks straight at the EX inputs.
  assign w_accept   = resetn & (r_state == S_IDLE) & in_valid & (|in_op) & ~in_except & ~flush;
  assign w_in_req   = (r_state == S_REQ);
  assign w_is_load  = |r_op[7:3];
  assign w_is_store = |r_op[2:0];
  assign w_load_data = f_load(r_op, r_addr[1:0], data_rdata);

  // Drops in the data_ok cycle so EX advances on the edge that registers the result.
  assign stallreq = w_accept | w_in_req
                  | ((r_state == S_WAIT) & ~data_data_ok)
                  | ((r_state == S_DROP) & in_valid & (|in_op));

  assign data_req   = w_in_req;
  assign data_wr    = w_in_req & w_is_store;
  assign data_size  = w_in_req ? f_size(r_op) : 2'd0;
  assign data_addr  = w_in_req ? r_addr : 32'd0;
  assign data_wdata = w_in_req ? f_wdata(r_op, r_wdata) : 32'd0;
  assign data_wstrb = w_in_req ? f_wstrb(r_op, r_addr[1:0]) : 4'd0;

  assign out_valid    = r_out_valid;
  assign out_rf_we    = r_out_rf_we;
  assign out_rf_waddr = r_out_rf_waddr;
  assign out_rdata    = r_out_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_op           <= 8'd0;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      r_waddr        <= 5'd0;
      r_out_valid    <= 1'b0;
      r_out_rf_we    <= 1'b0;
      r_out_rf_waddr <= 5'd0;
      r_out_rdata    <= 32'd0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_rf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= in_op;
            r_addr  <= in_addr;
            r_wdata <= in_wdata;
            r_waddr <= in_rf_waddr;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // Once addr_ok is seen the port owes a data_ok, so a flush must drain it.
          if (data_addr_ok)  r_state <= flush ? S_DROP : S_WAIT;
          else if (flush)    r_state <= S_IDLE;
        end
        S_WAIT: begin
          if (data_data_ok) begin
            r_state <= S_IDLE;
            if (!flush) begin
              r_out_valid    <= 1'b1;
              r_out_rf_we    <= w_is_load;
              r_out_rf_waddr <= r_waddr;
              r_out_rdata    <= w_is_load ? w_load_data : 32'd0;
            end
          end else if (flush) begin
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (data_data_ok) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_op;
  logic        in_except;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rf_waddr;
  logic        flush;
  logic        stallreq;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        out_valid;
  logic        out_rf_we;
  logic [4:0]  out_rf_waddr;
  logic [31:0] out_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] OP_LB  = 8'h80;
  localparam logic [7:0] OP_LHU = 8'h10;
  localparam logic [7:0] OP_LW  = 8'h08;
  localparam logic [7:0] OP_SB  = 8'h04;
  localparam logic [7:0] OP_SH  = 8'h02;
  localparam logic [7:0] OP_SW  = 8'h01;

  mem_lsu dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_op(in_op),
    .in_except(in_except), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rf_waddr(in_rf_waddr), .flush(flush), .stallreq(stallreq),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .out_valid(out_valid), .out_rf_we(out_rf_we),
    .out_rf_waddr(out_rf_waddr), .out_rdata(out_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs are driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_op = 0; in_except = 0; in_addr = 0; in_wdata = 0;
    in_rf_waddr = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
  endtask

  task automatic present(input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] wa);
    in_valid = 1; in_op = op; in_addr = a; in_wdata = wd; in_rf_waddr = wa;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    present(OP_LW, 32'h1234_5678, 32'hFFFF_FFFF, 5'd3);
    #2;
    n_tests++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", stallreq); end
    n_tests++; if (data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", data_req); end
    n_tests++; if (out_valid !== 1'b0 || out_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_out valid=%0b rdata=%h exp 0/0", out_valid, out_rdata); end
    step(); step();
    idle_inputs();
    resetn = 1;
    step();
  endtask

  task automatic test_lb();
    present(OP_LB, 32'h0000_1003, 32'd0, 5'd5);
    #1;
    n_tests++; if (stallreq !== 1'b1 || data_req !== 1'b0) begin n_fail++; $display("FAIL lb_accept stall=%0b req=%0b exp 1/0", stallreq, data_req); end
    step();
    idle_inputs(); data_addr_ok = 1;
    #1;
    n_tests++; if (data_req !== 1'b1 || data_size !== 2'd0 || data_wr !== 1'b0 || data_addr !== 32'h1003 || data_wstrb !== 4'd0)
      begin n_fail++; $display("FAIL lb_req req=%0b size=%0d wr=%0b addr=%h strb=%b exp 1/0/0/1003/0000", data_req, data_size, data_wr, data_addr, data_wstrb); end
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80FF_FF12;
    #1;
    n_tests++; if (data_req !== 1'b0 || stallreq !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL lb_dataok req=%0b stall=%0b valid=%0b exp 0/0/0", data_req, stallreq, out_valid); end
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_rf_we !== 1'b1 || out_rdata !== 32'hFFFF_FF80 || out_rf_waddr !== 5'd5)
      begin n_fail++; $display("FAIL lb_done valid=%0b we=%0b rdata=%h wa=%0d exp 1/1/ffffff80/5", out_valid, out_rf_we, out_rdata, out_rf_waddr); end
    step();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lb_pulse valid=%0b exp=0", out_valid); end
  endtask

  task automatic test_store(input string nm, input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] exp_size,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    present(op, a, wd, 5'd9);
    step();
    idle_inputs(); data_addr_ok = 1;
    #1;
    n_tests++; if (data_wr !== 1'b1 || data_size !== exp_size || data_wstrb !== exp_strb || data_wdata !== exp_wd || data_addr !== a)
      begin n_fail++; $display("FAIL %s_req wr=%0b size=%0d strb=%b wdata=%h addr=%h exp 1/%0d/%b/%h/%h", nm, data_wr, data_size, data_wstrb, data_wdata, data_addr, exp_size, exp_strb, exp_wd, a); end
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    step();
    data_data_ok = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_rf_we !== 1'b0 || out_rdata !== 32'd0)
      begin n_fail++; $display("FAIL %s_done valid=%0b we=%0b rdata=%h exp 1/0/0", nm, out_valid, out_rf_we, out_rdata); end
    step();
  endtask

  task automatic test_lw_stall();
    present(OP_LW, 32'h0000_3000, 32'd0, 5'd7);
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      #1;
      n_tests++; if (data_req !== 1'b1 || data_addr !== 32'h3000 || stallreq !== 1'b1 || data_size !== 2'd2)
        begin n_fail++; $display("FAIL lw_hold%0d req=%0b addr=%h stall=%0b size=%0d exp 1/3000/1/2", i, data_req, data_addr, stallreq, data_size); end
      step();
    end
    data_addr_ok = 0;
    #1;
    n_tests++; if (data_req !== 1'b0 || stallreq !== 1'b1) begin n_fail++; $display("FAIL lw_wait req=%0b stall=%0b exp 0/1", data_req, stallreq); end
    step();
    data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    #1;
    n_tests++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lw_stall_drop stall=%0b exp=0", stallreq); end
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_rdata !== 32'hCAFE_F00D || out_rf_waddr !== 5'd7)
      begin n_fail++; $display("FAIL lw_done valid=%0b rdata=%h wa=%0d exp 1/cafef00d/7", out_valid, out_rdata, out_rf_waddr); end
    step();
  endtask

  task automatic test_flush_drop();
    present(OP_LW, 32'h0000_4000, 32'd0, 5'd1);
    step();
    idle_inputs(); data_addr_ok = 1;
    step();
    data_addr_ok = 0; flush = 1;
    #1;
    n_tests++; if (stallreq !== 1'b1 || data_req !== 1'b0) begin n_fail++; $display("FAIL drop_flush stall=%0b req=%0b exp 1/0", stallreq, data_req); end
    step();
    flush = 0;
    present(OP_LW, 32'h0000_5000, 32'd0, 5'd2);
    #1;
    n_tests++; if (stallreq !== 1'b1 || data_req !== 1'b0) begin n_fail++; $display("FAIL drop_newstall stall=%0b req=%0b exp 1/0", stallreq, data_req); end
    step();
    data_data_ok = 1; data_rdata = 32'h5555_AAAA;
    #1;
    n_tests++; if (stallreq !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_dataok stall=%0b valid=%0b exp 1/0", stallreq, out_valid); end
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || stallreq !== 1'b1 || data_req !== 1'b0)
      begin n_fail++; $display("FAIL drop_novalid valid=%0b stall=%0b req=%0b exp 0/1/0", out_valid, stallreq, data_req); end
    step();
    idle_inputs(); data_addr_ok = 1;
    #1;
    n_tests++; if (data_req !== 1'b1 || data_addr !== 32'h5000) begin n_fail++; $display("FAIL drop_reissue req=%0b addr=%h exp 1/5000", data_req, data_addr); end
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344;
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_rdata !== 32'h1122_3344 || out_rf_waddr !== 5'd2)
      begin n_fail++; $display("FAIL drop_next valid=%0b rdata=%h wa=%0d exp 1/11223344/2", out_valid, out_rdata, out_rf_waddr); end
    step();
  endtask

  task automatic test_flush_req();
    present(OP_LW, 32'h0000_6000, 32'd0, 5'd4);
    step();
    idle_inputs(); flush = 1;
    #1;
    n_tests++; if (data_req !== 1'b1) begin n_fail++; $display("FAIL freq_req req=%0b exp=1", data_req); end
    step();
    flush = 0; data_data_ok = 1;
    #1;
    n_tests++; if (data_req !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("FAIL freq_withdrawn req=%0b stall=%0b exp 0/0", data_req, stallreq); end
    step();
    data_data_ok = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL freq_stale valid=%0b exp=0", out_valid); end
    step();
  endtask

  task automatic test_except();
    present(OP_SW, 32'h0000_7001, 32'hFFFF_0000, 5'd0);
    in_except = 1;
    #1;
    n_tests++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL except_stall stall=%0b exp=0", stallreq); end
    step();
    #1;
    n_tests++; if (data_req !== 1'b0 || stallreq !== 1'b0) begin n_fail++; $display("FAIL except_req req=%0b stall=%0b exp 0/0", data_req, stallreq); end
    step();
    idle_inputs();
    #1;
    n_tests++; if (out_valid !== 1'b0 || data_req !== 1'b0) begin n_fail++; $display("FAIL except_out valid=%0b req=%0b exp 0/0", out_valid, data_req); end
    step();
  endtask

  task automatic test_reset_midreq();
    present(OP_SW, 32'h0000_8000, 32'hA5A5_A5A5, 5'd0);
    step();
    idle_inputs();
    #1;
    n_tests++; if (data_req !== 1'b1 || data_wr !== 1'b1) begin n_fail++; $display("FAIL rmid_inreq req=%0b wr=%0b exp 1/1", data_req, data_wr); end
    #1;
    resetn = 0;
    #1;
    n_tests++; if (data_req !== 1'b0 || data_wr !== 1'b0 || stallreq !== 1'b0 || data_addr !== 32'd0 || data_wstrb !== 4'd0 || data_wdata !== 32'd0)
      begin n_fail++; $display("FAIL rmid_async req=%0b wr=%0b stall=%0b addr=%h strb=%b wd=%h exp all 0", data_req, data_wr, stallreq, data_addr, data_wstrb, data_wdata); end
    step();
    resetn = 1;
    data_data_ok = 1; data_addr_ok = 1;
    step();
    data_data_ok = 0; data_addr_ok = 0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || data_req !== 1'b0 || stallreq !== 1'b0)
      begin n_fail++; $display("FAIL rmid_idle valid=%0b req=%0b stall=%0b exp 0/0/0", out_valid, data_req, stallreq); end
    present(OP_LHU, 32'h0000_0000, 32'd0, 5'd12);
    step();
    idle_inputs(); data_addr_ok = 1;
    #1;
    n_tests++; if (data_req !== 1'b1 || data_size !== 2'd1 || data_wr !== 1'b0) begin n_fail++; $display("FAIL lhu_req req=%0b size=%0d wr=%0b exp 1/1/0", data_req, data_size, data_wr); end
    step();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1234_8765;
    step();
    data_data_ok = 0; data_rdata = 0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_rf_we !== 1'b1 || out_rdata !== 32'h0000_8765 || out_rf_waddr !== 5'd12)
      begin n_fail++; $display("FAIL lhu_done valid=%0b we=%0b rdata=%h wa=%0d exp 1/1/00008765/12", out_valid, out_rf_we, out_rdata, out_rf_waddr); end
    step();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_store("sh", OP_SH, 32'h0000_2002, 32'h0000_BEEF, 2'd1, 4'b1100, 32'hBEEF_BEEF);
    test_store("sb", OP_SB, 32'h0000_6001, 32'h1234_56A5, 2'd0, 4'b0010, 32'hA5A5_A5A5);
    test_store("sw", OP_SW, 32'h0000_6004, 32'h0BAD_CAFE, 2'd2, 4'b1111, 32'h0BAD_CAFE);
    test_lw_stall();
    test_flush_drop();
    test_flush_req();
    test_except();
    test_reset_midreq();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  EX stage presents an instruction this cycle.
REQ-005 in_op  in  8  one-hot {lb,lbu,lh,lhu,lw,sb,sh,sw}; all-zero means no memory access.
REQ-006 in_except  in  1  instruction already carries an exception (adel/ades/other); access suppressed.
REQ-007 in_addr  in  32  effective address from EX.
REQ-008 in_wdata  in  32  store data, unaligned in the low bits.
REQ-009 in_rf_waddr  in  5  load destination register.
REQ-010 flush  in  1  pipeline flush (exception/eret); kills the access in flight.
REQ-011 stallreq  out  1  holds EX and upstream stages.
REQ-012 data_req, data_wr  out  1 each  SRAM-like request and write flag.
REQ-013 data_size  out  2  0 byte, 1 half, 2 word.
REQ-014 data_addr, data_wdata  out  32 each  request address and lane-replicated store data.
REQ-015 data_wstrb  out  4  byte enables; 0 for loads.
REQ-016 data_addr_ok, data_data_ok  in  1 each  request accepted / response valid.
REQ-017 data_rdata  in  32  load response word.
REQ-018 out_valid  out  1  one-cycle completion pulse toward WB.
REQ-019 out_rf_we  out  1  completion is a load writing the register file.
REQ-020 out_rf_waddr  out  5  load destination.
REQ-021 out_rdata  out  32  extended load result.

Function
REQ-022 States SHALL be IDLE, REQ, WAIT, DROP.
REQ-023 accept = IDLE & in_valid & |in_op & ~in_except & ~flush; on accept, op, addr, wdata and waddr are latched and the next state is REQ.
REQ-024 REQ: data_req=1, all data_* outputs from the latched copy and stable until addr_ok.
- addr_ok & ~flush -> WAIT.
- addr_ok & flush -> DROP.
- ~addr_ok & flush -> IDLE, request withdrawn.
REQ-025 WAIT: data_req=0.
- data_ok & ~flush -> IDLE, and out_valid=1 on the next cycle.
- flush & ~data_ok -> DROP.
- flush & data_ok -> IDLE, no out_valid.
REQ-026 DROP: data_req=0; data_ok -> IDLE; out_valid is never raised for a dropped access.
REQ-027 stallreq = accept | REQ | (WAIT & ~data_ok) | (DROP & in_valid & |in_op).
- stallreq falls combinationally in the data_ok cycle so EX advances on the same edge the result is registered.
REQ-028 At most one access SHALL be outstanding; data_ok outside WAIT/DROP is ignored.
REQ-029 data_size SHALL be 0 for sb/lb/lbu, 1 for sh/lh/lhu, and 2 for sw/lw.
REQ-030 Store strobes SHALL be:
- sb: 4'b0001<<addr[1:0].
- sh: 4'b0011 if addr[1]=0, else 4'b1100.
- sw: 4'b1111.
REQ-031 data_wdata SHALL be {4{wdata[7:0]}} for sb, {2{wdata[15:0]}} for sh, and wdata for sw.
REQ-032 Load extraction SHALL select the byte by addr[1:0] and the half by addr[1].
- lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
REQ-033 out_valid SHALL be a registered one-cycle pulse; out_rf_we=1 only for loads; out_rdata=0 for stores.
REQ-034 The block performs no alignment checks; misaligned accesses arrive with in_except=1 and are never issued.

Reset
REQ-035 resetn=0 SHALL immediately force state IDLE, clear all latched fields, and hold every output at 0 (stallreq, data_req, data_wr, out_valid, out_rf_we, buses).
REQ-036 Reset deassertion mid-transaction SHALL leave the block in IDLE with no out_valid; any stale data_ok afterward is ignored per REQ-028.

Verification
REQ-037 lb, addr=0x1003, rdata=0x80FF_FF12, addr_ok and data_ok each one cycle after request -> data_req one cycle, data_size=0, out_valid at cycle 3 with out_rdata=0xFFFF_FF80 and out_rf_we=1.
REQ-038 sh, addr=0x2002, wdata=0x0000_BEEF -> data_wr=1, data_wstrb=4'b1100, data_wdata=0xBEEF_BEEF, out_valid with out_rf_we=0.
REQ-039 lw with addr_ok delayed 3 cycles -> data_req and data_addr held stable 4 cycles, stallreq high throughout and low in the data_ok cycle.
REQ-040 flush in WAIT, data_ok 2 cycles later -> state DROP then IDLE, no out_valid; a new lw presented during DROP is stalled and issues after data_ok.
REQ-041 in_except=1 with in_op=sw -> no data_req, stallreq=0, no out_valid.
REQ-042 resetn pulsed low while in REQ -> all outputs 0 asynchronously, IDLE after release; a subsequent lhu, addr=0x0, rdata=0x1234_8765 -> out_rdata=0x0000_8765.
